ifetch_stage: RTL and testbench

//  Multi-cycle instruction fetch stage for the Minisys core. Holds the PC and fetches

---
 rtl/minisys_pkg.sv | 23 ++
 rtl/ifetch_next_pc.sv | 39 +++
 rtl/ifetch_stage.sv | 141 ++++++++++++++
 tb/tb_ifetch_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/minisys_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : minisys_pkg
//  Brief    : Shared Minisys fetch constants, FSM state type and J-format fields
//  Revision : 1.0  initial release
// ============================================================================
package minisys_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_ERR   = 2'd2
    } fetch_state_t;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    // J-format: 26-bit word index in the low bits of the instruction
    localparam int c_J_INDEX_LSB = 0;
    localparam int c_J_INDEX_MSB = 25;
    localparam int c_J_INDEX_W   = c_J_INDEX_MSB - c_J_INDEX_LSB + 1;

endpackage : minisys_pkg
`default_nettype wire

// File: rtl/ifetch_next_pc.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_next_pc
//  Brief    : Combinational next-PC selector (JR > J/JAL > taken branch > pc+4)
//  Revision : 1.0  initial release
// ============================================================================
module ifetch_next_pc
    import minisys_pkg::*;
(
    input  logic [31:0]            pc_plus4,
    input  logic [c_J_INDEX_W-1:0] jump_index,
    input  logic [29:0]            branch_word,
    input  logic [29:0]            jr_word,
    input  logic                   Zero,
    input  logic                   Branch,
    input  logic                   nBranch,
    input  logic                   Jmp,
    input  logic                   Jal,
    input  logic                   Jrn,
    output logic [31:0]            next_pc
);

    logic w_taken;

    assign w_taken = (Branch & Zero) | (nBranch & ~Zero);

    always_comb begin
        next_pc = pc_plus4;
        if (Jrn) begin
            next_pc = {jr_word, 2'b00};
        end else if (Jmp | Jal) begin
            next_pc = {pc_plus4[31:28], jump_index, 2'b00};
        end else if (w_taken) begin
            next_pc = {branch_word, 2'b00};
        end
    end

endmodule : ifetch_next_pc
`default_nettype wire

// File: rtl/ifetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_stage
//  Brief    : Multi-cycle Minisys instruction fetch with req/ack imem and timeout
//  Revision : 1.0  initial release
// ============================================================================
module ifetch_stage
    import minisys_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC,
    parameter int          WAIT_MAX = 15
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic        instr_valid,
    input  logic        stall,
    output logic [31:0] PC_plus_4,
    output logic [31:0] opcplus4,
    input  logic [31:0] Add_Result,
    input  logic [31:0] Read_data_1,
    input  logic        Zero,
    input  logic        Branch,
    input  logic        nBranch,
    input  logic        Jmp,
    input  logic        Jal,
    input  logic        Jrn,
    output logic        fetch_err
);

    localparam int                 c_CNT_W     = $clog2(WAIT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(WAIT_MAX);

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [31:0]        r_pc;
    logic [31:0]        r_instr;
    logic [31:0]        r_opcplus4;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic [c_CNT_W-1:0] w_wait_inc;
    logic [31:0]        w_pc_plus4;
    logic [31:0]        w_next_pc;
    logic               w_capture;
    logic               w_retire;
    logic               w_unused;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_wait_inc  = r_wait_cnt + 1'b1;
    assign imem_addr   = r_pc;
    assign PC_plus_4   = w_pc_plus4;
    assign Instruction = r_instr;
    assign opcplus4    = r_opcplus4;

    // Bits that the target formulas drop by construction
    assign w_unused = &{1'b0, Read_data_1[1:0], Add_Result[31:30],
                        r_instr[31:c_J_INDEX_MSB+1]};

    ifetch_next_pc u_next_pc (
        .pc_plus4    (w_pc_plus4),
        .jump_index  (r_instr[c_J_INDEX_MSB:c_J_INDEX_LSB]),
        .branch_word (Add_Result[29:0]),
        .jr_word     (Read_data_1[31:2]),
        .Zero        (Zero),
        .Branch      (Branch),
        .nBranch     (nBranch),
        .Jmp         (Jmp),
        .Jal         (Jal),
        .Jrn         (Jrn),
        .next_pc     (w_next_pc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        imem_req     = 1'b0;
        instr_valid  = 1'b0;
        fetch_err    = 1'b0;
        w_capture    = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                // Request drops in the reset cycle so imem can abandon it
                imem_req = ~reset;
                if (imem_ack) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_EXEC;
                end else if (w_wait_inc == c_WAIT_LAST) begin
                    w_state_next = ST_ERR;
                end
            end
            ST_EXEC: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    w_retire     = 1'b1;
                    w_state_next = ST_FETCH;
                end
            end
            ST_ERR: begin
                fetch_err = 1'b1;
            end
            default: begin
                w_state_next = ST_ERR;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_instr    <= 32'h0;
            r_opcplus4 <= 32'h0;
            r_wait_cnt <= '0;
        end else begin
            if (r_state == ST_FETCH) begin
                r_wait_cnt <= imem_ack ? '0 : w_wait_inc;
            end
            if (w_capture) begin
                r_instr <= imem_rdata;
            end
            if (w_retire) begin
                r_pc <= w_next_pc;
                if (Jal) begin
                    r_opcplus4 <= w_pc_plus4;
                end
            end
        end
    end

endmodule : ifetch_stage
`default_nettype wire

// File: tb/tb_ifetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ifetch_stage
//  Brief    : Self-checking bench for ifetch_stage with a cycle-level model
//  Revision : 1.0  initial release
// ============================================================================
module tb_ifetch_stage;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam int          c_WAIT_MAX = 15;
    localparam int          c_M_FETCHING = 0;
    localparam int          c_M_EXECUTING = 1;
    localparam int          c_M_HALTED = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] Instruction;
    logic        instr_valid;
    logic        stall = 1'b0;
    logic [31:0] PC_plus_4;
    logic [31:0] opcplus4;
    logic [31:0] Add_Result = 32'h0;
    logic [31:0] Read_data_1 = 32'h0;
    logic        Zero = 1'b0;
    logic        Branch = 1'b0;
    logic        nBranch = 1'b0;
    logic        Jmp = 1'b0;
    logic        Jal = 1'b0;
    logic        Jrn = 1'b0;
    logic        fetch_err;

    int total = 0;
    int bad = 0;

    ifetch_stage #(.RESET_PC(c_RESET_PC), .WAIT_MAX(c_WAIT_MAX)) dut (
        .clock       (clk),
        .reset       (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .Instruction (Instruction),
        .instr_valid (instr_valid),
        .stall       (stall),
        .PC_plus_4   (PC_plus_4),
        .opcplus4    (opcplus4),
        .Add_Result  (Add_Result),
        .Read_data_1 (Read_data_1),
        .Zero        (Zero),
        .Branch      (Branch),
        .nBranch     (nBranch),
        .Jmp         (Jmp),
        .Jal         (Jal),
        .Jrn         (Jrn),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_mode = c_M_FETCHING;
    int          m_waited = 0;
    bit          m_live = 1'b0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_link = 32'h0;

    function automatic logic [31:0] model_target(input logic [31:0] pc, input logic [31:0] ins);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (Jrn)                                    return Read_data_1 & 32'hFFFF_FFFC;
        if (Jmp || Jal)                             return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
        if ((Branch && Zero) || (nBranch && !Zero)) return Add_Result * 4;
        return seq;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pc = c_RESET_PC; m_mode = c_M_FETCHING; m_instr = 0;
            m_link = 0; m_waited = 0; m_live = 1'b1;
        end else if (m_live) begin
            if (m_mode == c_M_FETCHING) begin
                if (imem_ack) begin
                    m_instr = imem_rdata; m_waited = 0; m_mode = c_M_EXECUTING;
                end else begin
                    m_waited++;
                    if (m_waited == c_WAIT_MAX) m_mode = c_M_HALTED;
                end
            end else if (m_mode == c_M_EXECUTING && !stall) begin
                if (Jal) m_link = m_pc + 32'd4;
                m_pc = model_target(m_pc, m_instr);
                m_mode = c_M_FETCHING;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("cyc_req",   {31'b0, imem_req},    {31'b0, (m_mode == c_M_FETCHING) && !rst});
            chk("cyc_addr",  imem_addr,            m_pc);
            chk("cyc_valid", {31'b0, instr_valid}, {31'b0, m_mode == c_M_EXECUTING});
            chk("cyc_err",   {31'b0, fetch_err},   {31'b0, m_mode == c_M_HALTED});
            chk("cyc_instr", Instruction,          m_instr);
            chk("cyc_pc4",   PC_plus_4,            m_pc + 32'd4);
            chk("cyc_link",  opcplus4,             m_link);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_word(input logic [31:0] w, input int waits);
        imem_rdata = 32'hBAD0_0BAD;
        for (int i = 0; i < waits; i++) tick();
        imem_ack = 1'b1;
        imem_rdata = w;
        tick();
        imem_ack = 1'b0;
        imem_rdata = 32'hBAD0_0BAD;
    endtask

    task automatic clear_ctl();
        Branch = 0; nBranch = 0; Jmp = 0; Jal = 0; Jrn = 0; Zero = 0;
        Add_Result = 0; Read_data_1 = 0; stall = 0;
    endtask

    initial begin
        tick();
        chk("req_in_reset", {31'b0, imem_req}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_req",   {31'b0, imem_req},    32'd1);
        chk("rst_addr",  imem_addr,            32'h0);
        chk("rst_instr", Instruction,          32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_link",  opcplus4,             32'h0);
        chk("rst_err",   {31'b0, fetch_err},   32'd0);

        fetch_word(32'h2001_0005, 2);
        chk("f1_instr", Instruction,          32'h2001_0005);
        chk("f1_valid", {31'b0, instr_valid}, 32'd1);
        chk("f1_addr",  imem_addr,            32'h0);
        tick();
        chk("f1_next_valid", {31'b0, instr_valid}, 32'd0);
        chk("f1_next_addr",  imem_addr,            32'h4);

        fetch_word(32'h0800_0010, 0); Jmp = 1; tick(); clear_ctl();
        chk("j_0x40", imem_addr, 32'h40);

        fetch_word(32'h1000_0008, 1); Branch = 1; Zero = 1; Add_Result = 32'h20; tick(); clear_ctl();
        chk("beq_taken", imem_addr, 32'h80);

        fetch_word(32'h0800_0010, 0); Jmp = 1; tick(); clear_ctl();
        fetch_word(32'h1000_0008, 0); Branch = 1; Zero = 0; Add_Result = 32'h20; tick(); clear_ctl();
        chk("beq_not_taken", imem_addr, 32'h44);

        fetch_word(32'h0800_0010, 0); Jmp = 1; tick(); clear_ctl();
        fetch_word(32'h1400_0008, 3); nBranch = 1; Zero = 0; Add_Result = 32'h20; tick(); clear_ctl();
        chk("bne_taken", imem_addr, 32'h80);

        fetch_word(32'h0800_0040, 0); Jmp = 1; tick(); clear_ctl();
        chk("j_0x100", imem_addr, 32'h100);

        fetch_word(32'h0C00_0010, 1); Jal = 1; tick(); clear_ctl();
        chk("jal_addr", imem_addr, 32'h40);
        chk("jal_link", opcplus4,  32'h104);

        fetch_word(32'h03E0_0008, 0); Jrn = 1; Read_data_1 = 32'h103; tick(); clear_ctl();
        chk("jr_aligned", imem_addr, 32'h100);
        chk("jr_link_kept", opcplus4, 32'h104);

        fetch_word(32'hDEAD_BEEF, 1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_instr", Instruction,          32'hDEAD_BEEF);
            chk("stall_addr",  imem_addr,            32'h100);
            chk("stall_req",   {31'b0, imem_req},    32'd0);
        end
        stall = 1'b0;
        tick();
        chk("stall_retire_addr",  imem_addr,            32'h104);
        chk("stall_retire_valid", {31'b0, instr_valid}, 32'd0);

        fetch_word(32'h03E0_0008, 0); Jrn = 1; Read_data_1 = 32'hFFFF_FFFE; tick(); clear_ctl();
        chk("wrap_pc",   imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pc4",  PC_plus_4, 32'h0);
        fetch_word(32'h0000_0000, 1); tick();
        chk("wrap_next", imem_addr, 32'h0);

        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_fetch_req", {31'b0, imem_req}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_addr", imem_addr, c_RESET_PC);

        for (int i = 0; i < c_WAIT_MAX - 1; i++) tick();
        chk("timeout_not_yet", {31'b0, fetch_err}, 32'd0);
        tick();
        chk("timeout_err", {31'b0, fetch_err}, 32'd1);
        chk("timeout_req", {31'b0, imem_req},  32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        imem_ack = 1'b0;
        chk("err_sticky", {31'b0, fetch_err},   32'd1);
        chk("err_valid",  {31'b0, instr_valid}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("err_cleared", {31'b0, fetch_err}, 32'd0);
        chk("err_rst_pc",  imem_addr,          c_RESET_PC);
        chk("err_rst_req", {31'b0, imem_req},  32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ifetch_stage
`default_nettype wire
